// File: rtl/pb_wb_bridge.sv
// -----------------------------------------------------------------------------
// pb_wb_bridge
//
// Purpose:
//   Bridges the PicoBlaze port-mapped I/O bus onto a Wishbone classic master.
//   Firmware fills the address, write-data and byte-select registers through
//   a 16-port window, writes CMD to launch one bus cycle, then polls STATUS or
//   waits for irq. The bridge handles err, rty (with a one-cycle backoff and a
//   bounded number of re-issues) and an optional per-attempt timeout.
//
// Register window (offset = port_id[3:0], hit when port_id[7:4] matches):
//   0-3   ADR bytes, little-endian (offset 0 = ADR[7:0])
//   4-7   write: WDATA bytes / read: RDATA bytes
//   8     SEL[3:0], upper bits read 0
//   9     write: CMD {ie, 6'b0, we} / read: STATUS {ie, 2'b0, ovr, tmo, err, done, busy}
//   10-15 reserved, read 0, writes ignored
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   port_id         PicoBlaze port address
//   write_strobe    single-cycle OUTPUT strobe, data on out_port
//   read_strobe     single-cycle INPUT strobe
//   in_port         registered read data, one cycle after port_id
//   irq             level interrupt, ie & done
//   wb_*            Wishbone classic master signals
//   o_dbg_state     current FSM state (0 idle, 1 cycle, 2 backoff)
//
// Handshake: a bus attempt is open while wb_cyc_o/wb_stb_o are high; it ends
// at the first rising edge where any of wb_ack_i, wb_err_i, wb_rty_i is high
// (ack > err > rty), or when the attempt has been open for TIMEOUT cycles.
// -----------------------------------------------------------------------------
module pb_wb_bridge #(
   parameter logic [7:0]  BASE_PORT = 8'h00,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  port_id,
   input  logic        write_strobe,
   input  logic        read_strobe,
   input  logic [7:0]  out_port,
   output logic [7:0]  in_port,
   output logic        irq,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CYCLE   = 2'd1,
      S_BACKOFF = 2'd2
   } state_t;

   localparam int unsigned TW = 16;
   // Last count value of an attempt; only meaningful when TIMEOUT != 0.
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);

   state_t         r_state;
   state_t         w_state_nxt;

   logic [31:0]    r_adr;
   logic [31:0]    r_wdata;
   logic [31:0]    r_rdata;
   logic [3:0]     r_sel;
   logic           r_we;
   logic           r_ie;
   logic           r_done;
   logic           r_err;
   logic           r_tmo;
   logic           r_ovr;
   logic [7:0]     r_retry;
   logic [TW-1:0]  r_tmo_cnt;
   logic [7:0]     r_in_port;

   logic           w_hit;
   logic [3:0]     w_off;
   logic           w_wr;
   logic           w_busy;
   logic           w_cmd_wr;
   logic           w_stat_clr;
   logic           w_tmo_hit;
   logic [7:0]     w_status;
   logic [7:0]     w_rd_data;

   // FSM control outputs
   logic           w_cyc;
   logic           w_start;
   logic           w_set_done;
   logic           w_set_err;
   logic           w_set_tmo;
   logic           w_latch_rd;
   logic           w_retry_inc;
   logic           w_tmo_clr;
   logic           w_tmo_inc;

   // --------------------------------------------------------------------------
   // Port decode
   // --------------------------------------------------------------------------
   assign w_hit      = (port_id[7:4] == BASE_PORT[7:4]);
   assign w_off      = port_id[3:0];
   assign w_wr       = write_strobe & w_hit;
   assign w_cmd_wr   = w_wr & (w_off == 4'd9);
   assign w_stat_clr = read_strobe & w_hit & (w_off == 4'd9);
   assign w_busy     = (r_state != S_IDLE);
   assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

   assign w_status   = {r_ie, 2'b00, r_ovr, r_tmo, r_err, r_done, w_busy};

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state and control strobes
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cyc       = 1'b0;
      w_start     = 1'b0;
      w_set_done  = 1'b0;
      w_set_err   = 1'b0;
      w_set_tmo   = 1'b0;
      w_latch_rd  = 1'b0;
      w_retry_inc = 1'b0;
      w_tmo_clr   = 1'b0;
      w_tmo_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_wr) begin
               w_start     = 1'b1;
               w_tmo_clr   = 1'b1;
               w_state_nxt = S_CYCLE;
            end
         end
         S_CYCLE: begin
            w_cyc = 1'b1;
            if (wb_ack_i) begin
               w_latch_rd  = ~r_we;
               w_set_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (wb_err_i) begin
               w_set_err   = 1'b1;
               w_set_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (wb_rty_i) begin
               if (r_retry < RETRY_MAX) begin
                  w_retry_inc = 1'b1;
                  w_state_nxt = S_BACKOFF;
               end else begin
                  // Retries exhausted: reported as a bus error.
                  w_set_err   = 1'b1;
                  w_set_done  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_tmo_hit) begin
               w_set_tmo   = 1'b1;
               w_set_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         S_BACKOFF: begin
            // One idle bus cycle, then re-issue with a fresh timeout window.
            w_tmo_clr   = 1'b1;
            w_state_nxt = S_CYCLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Read mux (sampled into in_port every cycle)
   // --------------------------------------------------------------------------
   always_comb begin
      w_rd_data = 8'h00;
      if (w_hit) begin
         case (w_off)
            4'd0:    w_rd_data = r_adr[7:0];
            4'd1:    w_rd_data = r_adr[15:8];
            4'd2:    w_rd_data = r_adr[23:16];
            4'd3:    w_rd_data = r_adr[31:24];
            4'd4:    w_rd_data = r_rdata[7:0];
            4'd5:    w_rd_data = r_rdata[15:8];
            4'd6:    w_rd_data = r_rdata[23:16];
            4'd7:    w_rd_data = r_rdata[31:24];
            4'd8:    w_rd_data = {4'h0, r_sel};
            4'd9:    w_rd_data = w_status;
            default: w_rd_data = 8'h00;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Datapath and status registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_adr     <= 32'h0;
         r_wdata   <= 32'h0;
         r_rdata   <= 32'h0;
         r_sel     <= 4'hF;
         r_we      <= 1'b0;
         r_ie      <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
         r_ovr     <= 1'b0;
         r_retry   <= 8'h0;
         r_tmo_cnt <= '0;
         r_in_port <= 8'h00;
      end else begin
         // Setup registers are frozen while a transaction is in flight.
         if (w_wr && !w_busy) begin
            case (w_off)
               4'd0:    r_adr[7:0]     <= out_port;
               4'd1:    r_adr[15:8]    <= out_port;
               4'd2:    r_adr[23:16]   <= out_port;
               4'd3:    r_adr[31:24]   <= out_port;
               4'd4:    r_wdata[7:0]   <= out_port;
               4'd5:    r_wdata[15:8]  <= out_port;
               4'd6:    r_wdata[23:16] <= out_port;
               4'd7:    r_wdata[31:24] <= out_port;
               4'd8:    r_sel          <= out_port[3:0];
               default: ;
            endcase
         end

         if (w_cmd_wr) begin
            r_ie <= out_port[7];
         end
         if (w_start) begin
            r_we <= out_port[0];
         end
         if (w_latch_rd) begin
            r_rdata <= wb_dat_i;
         end

         // Clear-on-read, but a same-cycle set takes precedence.
         r_done <= (r_done & ~w_stat_clr) | w_set_done;
         r_err  <= (r_err  & ~w_stat_clr) | w_set_err;
         r_tmo  <= (r_tmo  & ~w_stat_clr) | w_set_tmo;
         r_ovr  <= (r_ovr  & ~w_stat_clr) | (w_cmd_wr & w_busy);

         if (w_start) begin
            r_retry <= 8'h0;
         end else if (w_retry_inc) begin
            r_retry <= r_retry + 8'd1;
         end

         if (w_tmo_clr) begin
            r_tmo_cnt <= '0;
         end else if (w_tmo_inc) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end

         r_in_port <= w_rd_data;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign in_port     = r_in_port;
   assign irq         = r_ie & r_done;
   assign wb_adr_o    = r_adr;
   assign wb_dat_o    = r_wdata;
   assign wb_sel_o    = r_sel;
   assign wb_cyc_o    = w_cyc;
   assign wb_stb_o    = w_cyc;
   assign wb_we_o     = r_we;
   assign o_dbg_state = r_state;

endmodule

// File: doc/pb_wb_bridge.md
# pb_wb_bridge

Port-mapped bridge between the PicoBlaze I/O bus and a Wishbone classic master interface. It lets firmware reach 32-bit Wishbone slaves, primarily `uart_top` on `wb_adr[4:0]`, through a 16-port register window. Firmware loads address, data and byte-select registers, writes a command, then polls status or waits for an interrupt. The block sits between the CPU core and the UART/peripheral bus inside `picoblaze_advanced`.

## Interface
- `BASE_PORT`, 8'h00: register window base; only `[7:4]` is compared with `port_id[7:4]`.
- `TIMEOUT`, 255: maximum cycles to wait for ack/err/rty per attempt; 0 disables the timeout.
- `MAX_RETRY`, 3: number of re-issues allowed after `rty`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `port_id`  in  8  PicoBlaze port address.
- `write_strobe`  in  1  single-cycle OUTPUT strobe.
- `read_strobe`  in  1  single-cycle INPUT strobe.
- `out_port`  in  8  CPU write data.
- `in_port`  out  8  registered read data to CPU.
- `irq`  out  1  level interrupt to the IRQ controller.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_o`  out  32  Wishbone write data.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_sel_o`  out  4  byte selects.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone cycle, strobe and write enable.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1 each  Wishbone termination inputs.

## Operation
- The window is hit when `port_id[7:4]==BASE_PORT[7:4]`. The offset is `port_id[3:0]`.
- Register map:
  - 0–3: ADR bytes, little-endian (0 = `[7:0]`).
  - 4–7: DAT bytes. A write sets WDATA; a read returns RDATA.
  - 8: SEL `[3:0]`. Reset value 4'hF; upper bits read 0.
  - 9: write = CMD, read = STATUS.
  - 10–15: reserved, read 8'h00, writes ignored.
- CMD bits: bit0 = we, bit7 = ie. Writing CMD updates ie. If the FSM is IDLE, the write also starts a transaction with `wb_we_o=bit0`.
- STATUS bits: [0] busy, [1] done, [2] err, [3] tmo, [4] ovr, [7] ie. All other bits are 0.
- A read strobe at offset 9 clears done/err/tmo/ovr. Clearing takes effect at the end of that cycle.
- FSM states:
  - IDLE: on CMD write → CYCLE.
  - CYCLE: `cyc=stb=1`.
    - On ack: for a read, latch `wb_dat_i` into RDATA; set done; → IDLE.
    - On err: set err and done; → IDLE.
    - On rty with retries < MAX_RETRY: increment retries; → BACKOFF.
    - On rty with retries = MAX_RETRY: set err and done; → IDLE.
    - When the timeout counter reaches TIMEOUT: set tmo and done; → IDLE.
  - BACKOFF: `cyc=stb=0` for exactly one cycle; reset the timeout counter; → CYCLE.
- Retry count and timeout counter clear when a transaction starts.
- Termination priority when several inputs are high together: ack > err > rty > timeout.
- While busy:
  - Writes to ADR/DAT/SEL are ignored.
  - A CMD write updates ie only, and sets ovr.
- RDATA is updated only by a read-transaction ack.
- `irq = ie & done`.
- The Wishbone address, data and select outputs are driven continuously from the ADR, WDATA and SEL registers.

## Timing
- Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0.
  - `wb_adr_o`, `wb_dat_o` = 0; `wb_sel_o` = 4'hF.
  - `in_port` = 8'h00; `irq` = 0.
  - All status bits 0; FSM in IDLE.
- Reset asserted mid-transaction drops `cyc`/`stb` asynchronously; no completion is flagged.
- CMD write strobe in cycle N → `cyc`/`stb` high from N+1.
- Ack sampled at edge M → `cyc`/`stb` low and done=1 from M+1. RDATA is valid at M+1.
- Zero-wait-state slave (ack in the first cycle): the transaction is 1 bus cycle, and busy is high for exactly 1 cycle.
- `in_port` is registered from the current `port_id` every cycle, giving 1-cycle latency. This meets the PicoBlaze 2-cycle INPUT.
- A STATUS read returns the value before the clear.
- A completion event in the same cycle as a STATUS-read clear: the set wins, so the event is never lost.
- Timeout: with no response, CYCLE lasts exactly TIMEOUT cycles, then terminates.
- Each rty inserts exactly one idle BACKOFF cycle.

## Test plan
- UART LCR write: ADR=0x03, DAT0=0x83, SEL=4'h1, CMD=0x01 → one Wishbone write with `wb_adr_o=0x03`, `wb_dat_o[7:0]=0x83`, `wb_we_o=1`, and STATUS=0x02 afterwards.
- UART LSR read: ADR=0x05, CMD=0x80 → `wb_we_o=0`; RDATA byte 0 equals `uart_dat_o[7:0]` (0x60 after reset); `irq` rises at completion and clears after a STATUS read.
- Slave that never responds, TIMEOUT=8 → `cyc` high for exactly 8 cycles; STATUS=0x0A.
- Slave returning rty 4 times in a row, MAX_RETRY=3 → 4 attempts separated by 1-cycle gaps; STATUS=0x06.
- CMD rewrite while busy, plus ADR write while busy → ovr=1 in STATUS; ADR unchanged; only one transaction issued.
- Reset pulled low while `cyc` is high → `cyc`/`stb` go low immediately; STATUS=0x00 and SEL=4'hF after release.
